// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock-divider ratio controller.
// Ratios use the divider encoding where 0 stands for 2^RATIO_WID.
package clk_div_pkg;

    localparam int unsigned RATIO_WID = 8;

    typedef enum logic [0:0] {
        StIdle,
        StRamp
    } state_e;

    // Divider encoding -> effective value (0 maps to 2^RATIO_WID)
    function automatic logic [RATIO_WID:0] ratio_to_eff(input logic [RATIO_WID-1:0] r);
        return (r == '0) ? {1'b1, {RATIO_WID{1'b0}}} : {1'b0, r};
    endfunction

    function automatic logic [RATIO_WID-1:0] eff_to_ratio(input logic [RATIO_WID:0] e);
        return e[RATIO_WID-1:0];
    endfunction

endpackage

// File: rtl/clk_div_ratio_step.sv
// Combinational ramp step: moves cur_eff towards tgt_eff by at most step (0 = unlimited).
module clk_div_ratio_step #(
    parameter int unsigned RATIO_WID = 8
) (
    input  logic [RATIO_WID:0]   cur_eff,
    input  logic [RATIO_WID:0]   tgt_eff,
    input  logic [RATIO_WID-1:0] step,
    output logic [RATIO_WID:0]   nxt_eff,
    output logic                 reached
);

    logic                 up;
    logic [RATIO_WID:0]   diff;
    logic [RATIO_WID:0]   step_ext;

    always_comb begin
        up       = (tgt_eff >= cur_eff);
        diff     = up ? (tgt_eff - cur_eff) : (cur_eff - tgt_eff);
        step_ext = {1'b0, step};
        // diff > step guarantees the partial move stays strictly between cur and tgt
        if ((step == '0) || (diff <= step_ext)) begin
            nxt_eff = tgt_eff;
        end else if (up) begin
            nxt_eff = cur_eff + step_ext;
        end else begin
            nxt_eff = cur_eff - step_ext;
        end
        reached = (nxt_eff == tgt_eff);
    end

endmodule

// File: rtl/clk_div_ratio_ctrl.sv
// Owns the divider ratio: accepts change requests and applies them only on period
// boundaries, optionally ramping in bounded steps.
module clk_div_ratio_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned RATIO_WID = 8,
    parameter int unsigned RST_RATIO = 1
) (
    input  logic                 i_clk,
    input  logic                 rst,
    input  logic                 req_vld,
    input  logic [RATIO_WID-1:0] req_ratio,
    input  logic [RATIO_WID-1:0] req_step,
    output logic                 req_rdy,
    input  logic                 req_abort,
    input  logic                 div_en,
    output logic [RATIO_WID-1:0] ratio,
    output logic                 busy,
    output logic                 done
);

    state_e               state_q, state_d;
    logic [RATIO_WID-1:0] ratio_q, ratio_d;
    logic [RATIO_WID:0]   tgt_q, tgt_d;
    logic [RATIO_WID-1:0] step_q, step_d;
    logic                 done_q, done_d;

    logic [RATIO_WID:0]   cur_eff;
    logic [RATIO_WID:0]   req_eff;
    logic [RATIO_WID:0]   nxt_eff;
    logic                 reached;

    assign cur_eff = (ratio_q == '0) ? {1'b1, {RATIO_WID{1'b0}}} : {1'b0, ratio_q};
    assign req_eff = (req_ratio == '0) ? {1'b1, {RATIO_WID{1'b0}}} : {1'b0, req_ratio};

    clk_div_ratio_step #(
        .RATIO_WID (RATIO_WID)
    ) u_step (
        .cur_eff (cur_eff),
        .tgt_eff (tgt_q),
        .step    (step_q),
        .nxt_eff (nxt_eff),
        .reached (reached)
    );

    always_comb begin
        state_d = state_q;
        ratio_d = ratio_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_vld) begin
                    tgt_d   = req_eff;
                    step_d  = req_step;
                    state_d = StRamp;
                end
            end
            StRamp: begin
                // Abort beats a coincident boundary: the ratio is left untouched
                if (req_abort) begin
                    state_d = StIdle;
                end else if (div_en) begin
                    ratio_d = nxt_eff[RATIO_WID-1:0];
                    if (reached) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q <= StIdle;
            ratio_q <= RATIO_WID'(RST_RATIO);
            tgt_q   <= '0;
            step_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ratio_q <= ratio_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    assign req_rdy = (state_q == StIdle);
    assign busy    = (state_q == StRamp);
    assign ratio   = ratio_q;
    assign done    = done_q;

endmodule
